// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared configuration for the MFP UART transmitter: default line settings,
// FSM state encoding and the clocks-per-bit helper.
package mfp_uart_transmitter_pkg;

  localparam int MFP_UART_CLK_FREQ = 50_000_000;
  localparam int MFP_UART_BAUD     = 115_200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Rounded clocks per bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mfp_uart_transmitter_fifo.sv
// Small byte FIFO feeding the UART shifter; rdata always holds the current head
// in a register so the FSM can load it on the same edge it pops.
module mfp_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mfp_uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;
  logic             single;

  assign full       = (count_reg == (AW + 1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign single     = (count_reg == (AW + 1)'(1));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;
  assign rdata      = head_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // The head comes straight from wdata when the pushed byte becomes the head,
  // otherwise from the entry behind the one being popped.
  always_ff @(posedge clk) begin
    if (do_push && (empty || (do_pop && single))) begin
      head_reg <= wdata;
    end else if (do_pop && !single) begin
      head_reg <= mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter: buffers bytes from a ready/valid port and shifts them
// out LSB first at a fixed baud rate, with back-to-back frames and no idle gap.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLK_FREQ   = MFP_UART_CLK_FREQ,
  parameter int BAUD       = MFP_UART_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("mfp_uart_transmitter: CLK_FREQ/BAUD must give at least 2 clocks per bit");
    end
  endgenerate

  uart_state_t   state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          line_reg, line_next;
  logic          baud_tick;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  mfp_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_valid && tx_ready),
    .pop    (fifo_pop),
    .wdata  (tx_data),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign baud_tick = (baud_reg == '0);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;
    line_next  = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          bit_next   = 3'd0;
          baud_next  = BAUD_RELOAD;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          baud_next  = BAUD_RELOAD;
          state_next = ST_DATA;
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_next = BAUD_RELOAD;
          if (bit_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            shift_next = shift_reg >> 1;
            bit_next   = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          baud_next = BAUD_RELOAD;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rdata;
            bit_next   = 3'd0;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_next = baud_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Line level is precomputed from the next state so the pin comes from a flop.
    case (state_next)
      ST_START: line_next = 1'b0;
      ST_DATA:  line_next = shift_next[0];
      default:  line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      baud_reg  <= BAUD_RELOAD;
      bit_reg   <= 3'd0;
      shift_reg <= 8'h00;
      line_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      line_reg  <= line_next;
    end
  end

  assign uart_tx  = line_reg;
  assign tx_ready = !fifo_full;
  assign tx_busy  = (state_reg != ST_IDLE) || !fifo_empty;

endmodule
